hpdcache_req_issuer: RTL and testbench
======================================

Name: hpdcache_req_issuer

Overview:
Requester-side endpoint of the HPDcache core request/response port; one instance sits in each requester, in front of the cache's core arbiter.
- Accepts client requests, stamps the requester ID (sid) and a free transaction ID (tid), and drives the two-phase cache request: valid/req in the 1st cycle, then abort/tag/pma in the 2nd cycle.
- Tracks outstanding TIDs and releases them when matching responses return.
- Filters the shared response bus by sid and forwards matching responses to the client.

Parameters:
HPDcacheCfg, '0, cache configuration; uses u.tidWidth and u.sidWidth.
hpdcache_tag_t, logic, physical tag type.
hpdcache_req_t, logic, request type; has sid, tid and need_rsp fields.
hpdcache_rsp_t, logic, response type; has sid and tid fields.
SID, 0, requester ID stamped on every request.
NTID, 4, number of TIDs in the pool; 1 <= NTID <= 2**tidWidth.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
cli_req_valid_i  in  1  client request valid
cli_req_ready_o  out  1  client request ready
cli_req_i  in  $bits(hpdcache_req_t)  client request; sid/tid fields are ignored
cli_tag_i  in  $bits(hpdcache_tag_t)  tag, captured with the request
cli_pma_i  in  $bits(hpdcache_pma_t)  PMA, captured with the request
cli_kill_i  in  1  abort the request currently in its 2nd cycle
cli_rsp_valid_o  out  1  response to client
cli_rsp_o  out  $bits(hpdcache_rsp_t)  response payload
core_req_valid_o  out  1  cache request valid
core_req_ready_i  in  1  cache request ready
core_req_o  out  $bits(hpdcache_req_t)  cache request
core_req_abort_o  out  1  2nd-cycle abort
core_req_tag_o  out  $bits(hpdcache_tag_t)  2nd-cycle tag
core_req_pma_o  out  $bits(hpdcache_pma_t)  2nd-cycle PMA
core_rsp_valid_i  in  1  shared response valid
core_rsp_i  in  $bits(hpdcache_rsp_t)  shared response
flush_i  in  1  stop accepting new requests and drain outstanding ones
drained_o  out  1  high while in DRAIN and no TIDs are outstanding
outstanding_o  out  $clog2(NTID+1)  count of TIDs in use
err_o  out  1  sticky: response received for a TID not in use

Behaviour:
- Reset (synchronous, rst_ni=0 at a clock edge):
  - FSM goes to IDLE; free-TID bitmap set to all ones; outstanding=0; s2 stage cleared; err_o=0.
  - All valid outputs are 0; cli_req_ready_o=0 during reset.
  - Reset mid-transaction drops all state; late responses after reset set err_o.
- FSM states IDLE, HOLD, DRAIN:
  - IDLE: cli_req_ready_o = !flush_i && (!need_rsp || a free TID exists).
    - On client handshake: latch req/tag/pma into the hold register, stamp sid=SID, stamp tid = lowest free TID (0 if need_rsp=0), mark that TID busy if need_rsp=1, go to HOLD.
    - flush_i=1 in IDLE goes to DRAIN.
  - HOLD: core_req_valid_o=1 and core_req_o=hold register, both stable until core_req_ready_i.
    - On cache handshake: load the s2 stage; if no flush, go to IDLE.
    - A flush raised in HOLD takes effect after the handshake: go to DRAIN.
    - The client may not issue in HOLD (cli_req_ready_o=0). Throughput is therefore 1 request per 2 cycles; no bypass path.
  - DRAIN: cli_req_ready_o=0. drained_o = (outstanding==0). Leave for IDLE when flush_i=0.
- 2nd cycle (s2 stage): exactly one cycle after a cache handshake, drive core_req_tag_o and core_req_pma_o from s2, and core_req_abort_o = cli_kill_i (combinational) gated by s2_valid.
  - Aborted request with need_rsp=1: its TID is released in that same cycle, because the cache returns no response.
  - When s2_valid=0, tag/pma/abort outputs are 0.
- Response path:
  - match = core_rsp_valid_i && core_rsp_i.sid==SID.
  - cli_rsp_valid_o = match, combinational; cli_rsp_o = core_rsp_i. No backpressure on responses.
  - On match: if tid < NTID and the TID is busy, free it; otherwise set err_o and leave the bitmap unchanged.
- TID allocation and release in the same cycle: the released TID is not visible to the allocator until the next cycle (allocator reads the registered bitmap). outstanding_o is updated by +alloc -release in one step.
- A release from abort and a release from a response never target the same TID in one cycle; if they do, set err_o.

Decomposition:
- Put hpdcache_pma_t and the request/response field definitions in hpdcache_pkg; add no new package types.
- One sub-module: hpdcache_tid_pool (NTID bitmap, lowest-free priority encoder, alloc/release ports, count output).

Test Plan:
- Reset, then a single load with need_rsp=1 and SID=2: core_req_o.sid=2, tid=0; tag/pma appear exactly 1 cycle after the handshake; response with sid=2, tid=0 -> cli_rsp_valid_o=1, outstanding 1->0.
- NTID=4, issue 4 need_rsp requests with no responses: TIDs 0,1,2,3 issued; 5th request sees cli_req_ready_o=0; response with tid=2 -> next request gets tid=2.
- Hold core_req_ready_i=0 for 5 cycles: core_req_o stays stable; abort/tag outputs stay 0 until 1 cycle after ready.
- cli_kill_i=1 in the 2nd cycle of a tid=1 request: core_req_abort_o=1; outstanding decrements that cycle; tid=1 is reusable next cycle.
- Response with sid=3 while SID=2: no cli_rsp_valid_o. Response with sid=2, tid=3 while not busy: err_o=1 and stays set.
- flush_i with 2 outstanding: cli_req_ready_o=0; drained_o=0 until both responses return, then 1; drop flush_i -> accepting again.

Source files
------------

// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types: configuration, tag, PMA and the core request/response formats.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_TID_WIDTH = 4;
    localparam int unsigned HPDCACHE_SID_WIDTH = 3;
    localparam int unsigned HPDCACHE_TAG_WIDTH = 20;
    localparam int unsigned HPDCACHE_OFS_WIDTH = 12;
    localparam int unsigned HPDCACHE_WORD_WIDTH = 32;

    typedef struct packed {
        int unsigned tidWidth;
        int unsigned sidWidth;
    } hpdcache_user_cfg_t;

    typedef struct packed {
        hpdcache_user_cfg_t u;
    } hpdcache_cfg_t;

    localparam hpdcache_cfg_t HPDCACHE_CFG_DEFAULT = '{
        u: '{tidWidth: HPDCACHE_TID_WIDTH, sidWidth: HPDCACHE_SID_WIDTH}
    };

    typedef logic [HPDCACHE_TAG_WIDTH-1:0] hpdcache_tag_t;
    typedef logic [HPDCACHE_SID_WIDTH-1:0] hpdcache_req_sid_t;
    typedef logic [HPDCACHE_TID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef enum logic [1:0] {
        HPDCACHE_OP_LOAD  = 2'd0,
        HPDCACHE_OP_STORE = 2'd1,
        HPDCACHE_OP_AMO   = 2'd2,
        HPDCACHE_OP_CMO   = 2'd3
    } hpdcache_op_t;

    typedef struct packed {
        logic [HPDCACHE_OFS_WIDTH-1:0]  addr_offset;
        hpdcache_op_t                   op;
        logic [HPDCACHE_WORD_WIDTH-1:0] wdata;
        logic                           need_rsp;
        hpdcache_req_sid_t              sid;
        hpdcache_req_tid_t              tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [HPDCACHE_WORD_WIDTH-1:0] rdata;
        hpdcache_req_sid_t              sid;
        hpdcache_req_tid_t              tid;
        logic                           error;
    } hpdcache_rsp_t;

endpackage

// File: rtl/hpdcache_tid_pool.sv
// Pool of transaction IDs: free bitmap, lowest-free allocator, two release ports, in-use count.
module hpdcache_tid_pool #(
    parameter int unsigned NTID  = 4,
    parameter int unsigned TID_W = 4,
    localparam int unsigned CNT_W = $clog2(NTID + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_i,
    input  logic             rel_a_i,
    input  logic [TID_W-1:0] rel_a_tid_i,
    input  logic             rel_b_i,
    input  logic [TID_W-1:0] rel_b_tid_i,
    output logic             free_valid_o,
    output logic [TID_W-1:0] free_tid_o,
    output logic [NTID-1:0]  busy_o,
    output logic [CNT_W-1:0] count_o
);

    logic [NTID-1:0] r_free;
    logic [NTID-1:0] w_free_next;

    assign busy_o       = ~r_free;
    assign free_valid_o = |r_free;

    // Allocator only sees the registered bitmap, so a TID freed this cycle is handed out next cycle.
    always_comb begin
        free_tid_o = '0;
        for (int i = NTID - 1; i >= 0; i--) begin
            if (r_free[i]) free_tid_o = TID_W'(i);
        end
    end

    always_comb begin
        count_o = '0;
        for (int i = 0; i < NTID; i++) begin
            count_o = count_o + CNT_W'(busy_o[i]);
        end
    end

    for (genvar gi = 0; gi < NTID; gi++) begin : g_bit
        logic w_take;
        logic w_give;
        assign w_take = alloc_i && (free_tid_o == TID_W'(gi));
        assign w_give = (rel_a_i && (rel_a_tid_i == TID_W'(gi))) ||
                        (rel_b_i && (rel_b_tid_i == TID_W'(gi)));
        assign w_free_next[gi] = w_take ? 1'b0 : (w_give ? 1'b1 : r_free[gi]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_free <= '1;
        end else begin
            r_free <= w_free_next;
        end
    end

endmodule

// File: rtl/hpdcache_req_issuer.sv
// Requester-side endpoint of the HPDcache core port: stamps sid/tid, runs the two-phase
// request handshake, tracks outstanding TIDs and filters the shared response bus by sid.
module hpdcache_req_issuer
    import hpdcache_pkg::hpdcache_cfg_t;
    import hpdcache_pkg::hpdcache_pma_t;
#(
    parameter hpdcache_cfg_t HPDcacheCfg = hpdcache_pkg::HPDCACHE_CFG_DEFAULT,
    parameter type hpdcache_tag_t = hpdcache_pkg::hpdcache_tag_t,
    parameter type hpdcache_req_t = hpdcache_pkg::hpdcache_req_t,
    parameter type hpdcache_rsp_t = hpdcache_pkg::hpdcache_rsp_t,
    parameter int unsigned SID  = 0,
    parameter int unsigned NTID = 4,
    localparam int unsigned CNT_W = $clog2(NTID + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cli_req_valid_i,
    output logic             cli_req_ready_o,
    input  hpdcache_req_t    cli_req_i,
    input  hpdcache_tag_t    cli_tag_i,
    input  hpdcache_pma_t    cli_pma_i,
    input  logic             cli_kill_i,
    output logic             cli_rsp_valid_o,
    output hpdcache_rsp_t    cli_rsp_o,
    output logic             core_req_valid_o,
    input  logic             core_req_ready_i,
    output hpdcache_req_t    core_req_o,
    output logic             core_req_abort_o,
    output hpdcache_tag_t    core_req_tag_o,
    output hpdcache_pma_t    core_req_pma_o,
    input  logic             core_rsp_valid_i,
    input  hpdcache_rsp_t    core_rsp_i,
    input  logic             flush_i,
    output logic             drained_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);

    localparam int unsigned TID_W = HPDcacheCfg.u.tidWidth;
    localparam int unsigned SID_W = HPDcacheCfg.u.sidWidth;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DRAIN} state_e;

    state_e           r_state;
    hpdcache_req_t    r_hold_req;
    hpdcache_tag_t    r_hold_tag;
    hpdcache_pma_t    r_hold_pma;
    logic             r_s2_valid;
    logic             r_s2_need_rsp;
    logic [TID_W-1:0] r_s2_tid;
    hpdcache_tag_t    r_s2_tag;
    hpdcache_pma_t    r_s2_pma;
    logic             r_err;

    logic             w_free_valid;
    logic [TID_W-1:0] w_free_tid;
    logic [NTID-1:0]  w_busy;
    logic [CNT_W-1:0] w_count;
    logic             w_cli_ready;
    logic             w_cli_hs;
    logic             w_core_hs;
    logic             w_alloc;
    logic             w_abort;
    logic             w_rel_a;
    logic             w_rsp_match;
    logic             w_rsp_tid_busy;
    logic             w_rel_b;
    logic             w_rel_clash;

    assign w_cli_ready = rst_ni && (r_state == ST_IDLE) && !flush_i &&
                         (!cli_req_i.need_rsp || w_free_valid);
    assign w_cli_hs    = cli_req_valid_i && w_cli_ready;
    assign w_core_hs   = (r_state == ST_HOLD) && core_req_ready_i;
    assign w_alloc     = w_cli_hs && cli_req_i.need_rsp;

    // An aborted request never gets a response, so its TID goes back to the pool right away.
    assign w_abort = r_s2_valid && cli_kill_i;
    assign w_rel_a = w_abort && r_s2_need_rsp;

    assign w_rsp_match = core_rsp_valid_i && (core_rsp_i.sid == SID_W'(SID));

    always_comb begin
        w_rsp_tid_busy = 1'b0;
        for (int i = 0; i < NTID; i++) begin
            if (core_rsp_i.tid == TID_W'(i)) w_rsp_tid_busy = w_busy[i];
        end
    end

    assign w_rel_b     = w_rsp_match && w_rsp_tid_busy;
    assign w_rel_clash = w_rel_a && w_rel_b && (r_s2_tid == core_rsp_i.tid);

    hpdcache_tid_pool #(
        .NTID  (NTID),
        .TID_W (TID_W)
    ) u_tid_pool (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (w_alloc),
        .rel_a_i      (w_rel_a),
        .rel_a_tid_i  (r_s2_tid),
        .rel_b_i      (w_rel_b),
        .rel_b_tid_i  (core_rsp_i.tid),
        .free_valid_o (w_free_valid),
        .free_tid_o   (w_free_tid),
        .busy_o       (w_busy),
        .count_o      (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_hold_req    <= '0;
            r_hold_tag    <= '0;
            r_hold_pma    <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_need_rsp <= 1'b0;
            r_s2_tid      <= '0;
            r_s2_tag      <= '0;
            r_s2_pma      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_s2_valid <= w_core_hs;
            if (w_core_hs) begin
                r_s2_need_rsp <= r_hold_req.need_rsp;
                r_s2_tid      <= r_hold_req.tid;
                r_s2_tag      <= r_hold_tag;
                r_s2_pma      <= r_hold_pma;
            end
            if ((w_rsp_match && !w_rsp_tid_busy) || w_rel_clash) r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (flush_i) begin
                        r_state <= ST_DRAIN;
                    end else if (w_cli_hs) begin
                        r_hold_req     <= cli_req_i;
                        r_hold_req.sid <= SID_W'(SID);
                        r_hold_req.tid <= cli_req_i.need_rsp ? w_free_tid : '0;
                        r_hold_tag     <= cli_tag_i;
                        r_hold_pma     <= cli_pma_i;
                        r_state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_core_hs) r_state <= flush_i ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (!flush_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cli_req_ready_o  = w_cli_ready;
    assign cli_rsp_valid_o  = rst_ni && w_rsp_match;
    assign cli_rsp_o        = core_rsp_i;
    assign core_req_valid_o = (r_state == ST_HOLD);
    assign core_req_o       = r_hold_req;
    assign core_req_abort_o = w_abort;
    assign core_req_tag_o   = r_s2_valid ? r_s2_tag : '0;
    assign core_req_pma_o   = r_s2_valid ? r_s2_pma : '0;
    assign drained_o        = (r_state == ST_DRAIN) && (w_count == '0);
    assign outstanding_o    = w_count;
    assign err_o            = r_err;

endmodule

// File: tb/tb_hpdcache_req_issuer.sv
// Self-checking bench for hpdcache_req_issuer (SID=2, NTID=4) with a request/TID scoreboard.
module tb_hpdcache_req_issuer;

    localparam int unsigned TB_SID  = 2;
    localparam int unsigned TB_NTID = 4;

    typedef struct {
        logic [3:0]                 tid;
        logic                       need;
        logic [11:0]                addr;
        hpdcache_pkg::hpdcache_tag_t tag;
        hpdcache_pkg::hpdcache_pma_t pma;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst_ni;
    logic                         cli_req_valid_i;
    logic                         cli_req_ready_o;
    hpdcache_pkg::hpdcache_req_t  cli_req_i;
    hpdcache_pkg::hpdcache_tag_t  cli_tag_i;
    hpdcache_pkg::hpdcache_pma_t  cli_pma_i;
    logic                         cli_kill_i;
    logic                         cli_rsp_valid_o;
    hpdcache_pkg::hpdcache_rsp_t  cli_rsp_o;
    logic                         core_req_valid_o;
    logic                         core_req_ready_i;
    hpdcache_pkg::hpdcache_req_t  core_req_o;
    logic                         core_req_abort_o;
    hpdcache_pkg::hpdcache_tag_t  core_req_tag_o;
    hpdcache_pkg::hpdcache_pma_t  core_req_pma_o;
    logic                         core_rsp_valid_i;
    hpdcache_pkg::hpdcache_rsp_t  core_rsp_i;
    logic                         flush_i;
    logic                         drained_o;
    logic [2:0]                   outstanding_o;
    logic                         err_o;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic [3:0] model_busy;
    logic       model_err;
    bit         s2_pend;
    exp_t       s2_exp;
    exp_t       m_e;
    bit         m_abort_rel;
    logic [3:0] m_abort_tid;
    logic [3:0] m_lt;

    always #5 clk = ~clk;

    hpdcache_req_issuer #(
        .SID  (TB_SID),
        .NTID (TB_NTID)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .cli_req_valid_i  (cli_req_valid_i),
        .cli_req_ready_o  (cli_req_ready_o),
        .cli_req_i        (cli_req_i),
        .cli_tag_i        (cli_tag_i),
        .cli_pma_i        (cli_pma_i),
        .cli_kill_i       (cli_kill_i),
        .cli_rsp_valid_o  (cli_rsp_valid_o),
        .cli_rsp_o        (cli_rsp_o),
        .core_req_valid_o (core_req_valid_o),
        .core_req_ready_i (core_req_ready_i),
        .core_req_o       (core_req_o),
        .core_req_abort_o (core_req_abort_o),
        .core_req_tag_o   (core_req_tag_o),
        .core_req_pma_o   (core_req_pma_o),
        .core_rsp_valid_i (core_rsp_valid_i),
        .core_rsp_i       (core_rsp_i),
        .flush_i          (flush_i),
        .drained_o        (drained_o),
        .outstanding_o    (outstanding_o),
        .err_o            (err_o)
    );

    // Scoreboard / reference model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            model_busy = '0;
            model_err  = 1'b0;
            s2_pend    = 1'b0;
        end else begin
            total++;
            if (outstanding_o !== 3'($countones(model_busy))) begin
                bad++;
                $display("FAIL mon_outstanding: got %0d want %0d", outstanding_o, $countones(model_busy));
            end
            total++;
            if (err_o !== model_err) begin
                bad++;
                $display("FAIL mon_err: got %0b want %0b", err_o, model_err);
            end
            if (s2_pend) begin
                total++;
                if (core_req_tag_o !== s2_exp.tag || core_req_pma_o !== s2_exp.pma) begin
                    bad++;
                    $display("FAIL mon_s2_tag_pma: got %0h/%0h want %0h/%0h",
                             core_req_tag_o, core_req_pma_o, s2_exp.tag, s2_exp.pma);
                end
                total++;
                if (core_req_abort_o !== cli_kill_i) begin
                    bad++;
                    $display("FAIL mon_abort: got %0b want %0b", core_req_abort_o, cli_kill_i);
                end
            end else begin
                total++;
                if (core_req_tag_o !== '0 || core_req_pma_o !== '0 || core_req_abort_o !== 1'b0) begin
                    bad++;
                    $display("FAIL mon_s2_idle: got tag=%0h pma=%0h abort=%0b want 0/0/0",
                             core_req_tag_o, core_req_pma_o, core_req_abort_o);
                end
            end
            m_abort_rel = s2_pend && cli_kill_i && s2_exp.need;
            m_abort_tid = s2_exp.tid;
            s2_pend     = 1'b0;

            if (core_req_valid_o && core_req_ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL mon_unexpected_req: got tid=%0d want no request", core_req_o.tid);
                end else begin
                    m_e = exp_q.pop_front();
                    if (core_req_o.sid !== 3'(TB_SID) || core_req_o.tid !== m_e.tid ||
                        core_req_o.addr_offset !== m_e.addr || core_req_o.need_rsp !== m_e.need) begin
                        bad++;
                        $display("FAIL mon_core_req: got sid=%0d tid=%0d addr=%0h need=%0b want sid=%0d tid=%0d addr=%0h need=%0b",
                                 core_req_o.sid, core_req_o.tid, core_req_o.addr_offset, core_req_o.need_rsp,
                                 TB_SID, m_e.tid, m_e.addr, m_e.need);
                    end
                    s2_pend = 1'b1;
                    s2_exp  = m_e;
                end
            end

            if (cli_req_valid_i && cli_req_ready_o) begin
                m_lt = 4'd0;
                if (cli_req_i.need_rsp) begin
                    for (int i = TB_NTID - 1; i >= 0; i--) begin
                        if (!model_busy[i]) m_lt = 4'(i);
                    end
                    model_busy[m_lt] = 1'b1;
                end
                m_e.tid  = m_lt;
                m_e.need = cli_req_i.need_rsp;
                m_e.addr = cli_req_i.addr_offset;
                m_e.tag  = cli_tag_i;
                m_e.pma  = cli_pma_i;
                exp_q.push_back(m_e);
            end

            if (m_abort_rel) model_busy[m_abort_tid] = 1'b0;

            if (core_rsp_valid_i) begin
                total++;
                if (core_rsp_i.sid == 3'(TB_SID)) begin
                    if (cli_rsp_valid_o !== 1'b1 || cli_rsp_o !== core_rsp_i) begin
                        bad++;
                        $display("FAIL mon_rsp_fwd: got valid=%0b rsp=%0h want valid=1 rsp=%0h",
                                 cli_rsp_valid_o, cli_rsp_o, core_rsp_i);
                    end
                    if (core_rsp_i.tid < 4'(TB_NTID) && model_busy[core_rsp_i.tid[1:0]])
                        model_busy[core_rsp_i.tid[1:0]] = 1'b0;
                    else
                        model_err = 1'b1;
                end else if (cli_rsp_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL mon_rsp_filter: got valid=%0b want 0", cli_rsp_valid_o);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic need, input logic [11:0] addr, input logic [19:0] tag);
        bit hs;
        hs = 1'b0;
        cli_req_valid_i       = 1'b1;
        cli_req_i             = '0;
        cli_req_i.need_rsp    = need;
        cli_req_i.addr_offset = addr;
        cli_req_i.op          = need ? hpdcache_pkg::HPDCACHE_OP_LOAD : hpdcache_pkg::HPDCACHE_OP_STORE;
        cli_req_i.wdata       = $urandom;
        cli_req_i.sid         = 3'd7;
        cli_req_i.tid         = 4'd15;
        cli_tag_i             = tag;
        cli_pma_i             = 2'($urandom_range(0, 3));
        #1;
        for (int n = 0; n < 20; n++) begin
            hs = cli_req_ready_o;
            cyc();
            if (hs) break;
        end
        cli_req_valid_i = 1'b0;
        total++;
        if (!hs) begin
            bad++;
            $display("FAIL send_timeout: got no handshake want handshake within 20 cycles");
        end
    endtask

    task automatic rsp_on(input logic [2:0] sid, input logic [3:0] tid);
        core_rsp_valid_i = 1'b1;
        core_rsp_i       = '0;
        core_rsp_i.sid   = sid;
        core_rsp_i.tid   = tid;
        core_rsp_i.rdata = $urandom;
    endtask

    task automatic rsp_pulse(input logic [2:0] sid, input logic [3:0] tid);
        rsp_on(sid, tid);
        cyc();
        core_rsp_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        cli_req_valid_i = 1'b1;
        cli_req_i = '0;
        cli_req_i.need_rsp = 1'b1;
        rsp_on(3'(TB_SID), 4'd0);
        repeat (3) cyc();
        total++;
        if (cli_req_ready_o !== 1'b0 || core_req_valid_o !== 1'b0 || cli_rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_valids: got ready=%0b creq=%0b crsp=%0b want 0/0/0",
                     cli_req_ready_o, core_req_valid_o, cli_rsp_valid_o);
        end
        total++;
        if (outstanding_o !== 3'd0 || err_o !== 1'b0 || drained_o !== 1'b0 || core_req_abort_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got out=%0d err=%0b drained=%0b abort=%0b want 0/0/0/0",
                     outstanding_o, err_o, drained_o, core_req_abort_o);
        end
        cli_req_valid_i  = 1'b0;
        core_rsp_valid_i = 1'b0;
        rst_ni = 1'b1;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_single();
        send(1'b1, 12'h123, 20'hABCDE);
        #1;
        total++;
        if (core_req_valid_o !== 1'b1 || core_req_o.sid !== 3'd2 || core_req_o.tid !== 4'd0 || core_req_tag_o !== '0) begin
            bad++;
            $display("FAIL single_req: got v=%0b sid=%0d tid=%0d tag=%0h want 1/2/0/0",
                     core_req_valid_o, core_req_o.sid, core_req_o.tid, core_req_tag_o);
        end
        cyc();
        total++;
        if (core_req_tag_o !== 20'hABCDE || outstanding_o !== 3'd1) begin
            bad++;
            $display("FAIL single_s2: got tag=%0h out=%0d want abcde/1", core_req_tag_o, outstanding_o);
        end
        cyc();
        rsp_on(3'd2, 4'd0);
        #1;
        total++;
        if (cli_rsp_valid_o !== 1'b1 || cli_rsp_o.tid !== 4'd0) begin
            bad++;
            $display("FAIL single_rsp: got v=%0b tid=%0d want 1/0", cli_rsp_valid_o, cli_rsp_o.tid);
        end
        cyc();
        core_rsp_valid_i = 1'b0;
        total++;
        if (outstanding_o !== 3'd0) begin
            bad++;
            $display("FAIL single_release: got out=%0d want 0", outstanding_o);
        end
        $display("test_single done");
    endtask

    task automatic test_tid_exhaust();
        for (int i = 0; i < 4; i++) send(1'b1, 12'(16 * i), 20'($urandom));
        cyc();
        cyc();
        cli_req_valid_i = 1'b1;
        cli_req_i.need_rsp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (cli_req_ready_o !== 1'b0 || outstanding_o !== 3'd4) begin
                bad++;
                $display("FAIL exhaust_ready: got ready=%0b out=%0d want 0/4", cli_req_ready_o, outstanding_o);
            end
            cyc();
        end
        cli_req_valid_i = 1'b0;
        send(1'b0, 12'h0F0, 20'h11111);
        cyc();
        cyc();
        rsp_on(3'd2, 4'd2);
        #1;
        total++;
        if (cli_rsp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL exhaust_rsp: got v=%0b want 1", cli_rsp_valid_o);
        end
        cyc();
        core_rsp_valid_i = 1'b0;
        send(1'b1, 12'h222, 20'h22222);
        #1;
        total++;
        if (core_req_o.tid !== 4'd2) begin
            bad++;
            $display("FAIL exhaust_reuse: got tid=%0d want 2", core_req_o.tid);
        end
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) rsp_pulse(3'd2, 4'(i));
        cyc();
        $display("test_tid_exhaust done");
    endtask

    task automatic test_backpressure();
        core_req_ready_i = 1'b0;
        send(1'b1, 12'h5A5, 20'h5A5A5);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (core_req_valid_o !== 1'b1 || core_req_o.tid !== 4'd0 || core_req_o.addr_offset !== 12'h5A5 ||
                core_req_o.sid !== 3'd2 || core_req_tag_o !== '0 || core_req_abort_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_stable: got v=%0b tid=%0d addr=%0h tag=%0h want 1/0/5a5/0",
                         core_req_valid_o, core_req_o.tid, core_req_o.addr_offset, core_req_tag_o);
            end
            cyc();
        end
        core_req_ready_i = 1'b1;
        cyc();
        total++;
        if (core_req_tag_o !== 20'h5A5A5 || core_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_s2: got tag=%0h v=%0b want 5a5a5/0", core_req_tag_o, core_req_valid_o);
        end
        cyc();
        rsp_pulse(3'd2, 4'd0);
        cyc();
        $display("test_backpressure done");
    endtask

    task automatic test_kill();
        send(1'b1, 12'h010, 20'h00010);
        cyc();
        send(1'b1, 12'h011, 20'h00011);
        cyc();
        cli_kill_i = 1'b1;
        #1;
        total++;
        if (core_req_abort_o !== 1'b1 || outstanding_o !== 3'd2) begin
            bad++;
            $display("FAIL kill_abort: got abort=%0b out=%0d want 1/2", core_req_abort_o, outstanding_o);
        end
        cyc();
        cli_kill_i = 1'b0;
        total++;
        if (outstanding_o !== 3'd1 || core_req_abort_o !== 1'b0) begin
            bad++;
            $display("FAIL kill_release: got out=%0d abort=%0b want 1/0", outstanding_o, core_req_abort_o);
        end
        send(1'b1, 12'h012, 20'h00012);
        #1;
        total++;
        if (core_req_o.tid !== 4'd1) begin
            bad++;
            $display("FAIL kill_reuse: got tid=%0d want 1", core_req_o.tid);
        end
        cyc();
        cyc();
        rsp_pulse(3'd2, 4'd0);
        rsp_pulse(3'd2, 4'd1);
        cyc();
        $display("test_kill done");
    endtask

    task automatic test_flush();
        send(1'b1, 12'h100, 20'h00100);
        send(1'b1, 12'h101, 20'h00101);
        cyc();
        cyc();
        flush_i = 1'b1;
        cli_req_valid_i = 1'b1;
        cli_req_i.need_rsp = 1'b1;
        cli_req_i.addr_offset = 12'h102;
        #1;
        total++;
        if (cli_req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: got %0b want 0", cli_req_ready_o);
        end
        cyc();
        total++;
        if (drained_o !== 1'b0 || cli_req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain0: got drained=%0b ready=%0b want 0/0", drained_o, cli_req_ready_o);
        end
        rsp_pulse(3'd2, 4'd0);
        total++;
        if (drained_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_drain1: got drained=%0b want 0", drained_o);
        end
        rsp_pulse(3'd2, 4'd1);
        total++;
        if (drained_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_drained: got drained=%0b want 1", drained_o);
        end
        flush_i = 1'b0;
        cyc();
        total++;
        if (cli_req_ready_o !== 1'b1 || drained_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_resume: got ready=%0b drained=%0b want 1/0", cli_req_ready_o, drained_o);
        end
        cyc();
        cli_req_valid_i = 1'b0;
        cyc();
        cyc();
        rsp_pulse(3'd2, 4'd0);
        cyc();
        $display("test_flush done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) send(1'b0, 12'($urandom), 20'($urandom));
        for (int i = 0; i < 3; i++) send(1'b1, 12'($urandom), 20'($urandom));
        cyc();
        cyc();
        total++;
        if (outstanding_o !== 3'd3) begin
            bad++;
            $display("FAIL b2b_out: got %0d want 3", outstanding_o);
        end
        for (int i = 2; i >= 0; i--) rsp_pulse(3'd2, 4'(i));
        cyc();
        $display("test_back_to_back done");
    endtask

    task automatic test_filter_err();
        rsp_on(3'd3, 4'd0);
        #1;
        total++;
        if (cli_rsp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL filter_sid: got v=%0b want 0", cli_rsp_valid_o);
        end
        cyc();
        core_rsp_valid_i = 1'b0;
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL filter_noerr: got err=%0b want 0", err_o);
        end
        rsp_pulse(3'd2, 4'd3);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (err_o !== 1'b1) begin
                bad++;
                $display("FAIL err_sticky: got err=%0b want 1", err_o);
            end
            cyc();
        end
        rsp_pulse(3'd2, 4'd9);
        cyc();
        $display("test_filter_err done");
    endtask

    task automatic test_reset_mid();
        send(1'b1, 12'h3C3, 20'h3C3C3);
        rst_ni = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
        #1;
        total++;
        if (outstanding_o !== 3'd0 || core_req_valid_o !== 1'b0 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state: got out=%0d v=%0b err=%0b want 0/0/0",
                     outstanding_o, core_req_valid_o, err_o);
        end
        cyc();
        rsp_pulse(3'd2, 4'd0);
        total++;
        if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_late_rsp: got err=%0b want 1", err_o);
        end
        cyc();
        $display("test_reset_mid done");
    endtask

    initial begin
        rst_ni           = 1'b0;
        cli_req_valid_i  = 1'b0;
        cli_req_i        = '0;
        cli_tag_i        = '0;
        cli_pma_i        = '0;
        cli_kill_i       = 1'b0;
        core_req_ready_i = 1'b1;
        core_rsp_valid_i = 1'b0;
        core_rsp_i       = '0;
        flush_i          = 1'b0;
        test_reset();
        test_single();
        test_tid_exhaust();
        test_backpressure();
        test_kill();
        test_flush();
        test_back_to_back();
        test_filter_err();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
